regfile_mp: RTL
===============

Name: regfile_mp

Overview:
- Parametrised multi-port integer register file; successor to the single-write, dual-read regfile in the core.
- Provides NRD combinational read ports and NWR synchronous write ports with deterministic write-port priority.
- Holds a per-register busy scoreboard, set at issue and cleared at writeback, and reports per-read-port hazard status to the issue/stall logic.
- Sits between decode/issue and the execute/writeback stages.

Parameters:
XLEN, 64, data width of each register
NREGS, 32, number of architectural registers (power of two, >= 2); x0 is hardwired to zero
NRD, 2, number of read ports
NWR, 1, number of write ports
AW, $clog2(NREGS), address width (derived; do not override)

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
rd_addr  input  NRD*AW  read addresses; port i occupies bits [i*AW +: AW]
rd_data  output  NRD*XLEN  read data, port i at [i*XLEN +: XLEN]
rd_busy  output  NRD  port i: the addressed register has a pending producer
wr_en  input  NWR  write enable, one bit per write port
wr_addr  input  NWR*AW  write addresses
wr_data  input  NWR*XLEN  write data
iss_en  input  1  issue of an instruction with a destination register
iss_rd  input  AW  destination register of the issued instruction
busy_vec  output  NREGS  raw scoreboard, bit k = register k busy; bit 0 is always 0

Behaviour:
- Reset (rst_n low, asynchronous):
  - All registers become 0 and all busy bits become 0.
  - rd_data is therefore all-zero and rd_busy is 0 while reset is held.
  - Release is synchronous to clk by integration; the block itself takes no action on release.
- Reads:
  - Combinational, zero latency.
  - Address 0 always returns 0 with rd_busy=0.
  - Without the optional bypass, rd_data shows the register contents as of the last clock edge.
- Writes:
  - Take effect at the rising edge when wr_en[j]=1 and wr_addr[j]!=0.
  - Writes to x0 are discarded and do not touch the scoreboard.
- Write conflict: when several ports write the same address in one cycle, the highest-index port wins, for both data and bypass.
- Scoreboard, evaluated at each rising edge:
  - A writeback clears busy[wr_addr[j]] for every enabled port j with wr_addr[j]!=0.
  - iss_en=1 with iss_rd!=0 sets busy[iss_rd].
  - If a set and a clear hit the same register in the same cycle, the set wins: the busy bit ends at 1 because a newer producer was issued.
  - iss_rd=0 is ignored.
- rd_busy[i] = busy[rd_addr[i]] (0 for x0). It is combinational from the addresses and scoreboard state.
- Mid-operation reset: in-flight writes and issues on the asserting edge are lost. The reset value always wins over same-cycle updates.
- Reads never stall and never modify state. Read ports are independent, and any number may address the same register.

Optional Feature:
- Macro: REGFILE_BYPASS_EN
- Defined:
  - A read whose address matches an enabled, non-zero write in the same cycle returns that wr_data combinationally, using the highest-index matching port.
  - rd_busy for that port is forced to 0 for that cycle, unless iss_en targets the same register in the same cycle, in which case rd_busy stays at the current busy bit.
- Undefined:
  - No forwarding; same-cycle reads return the old value.
  - rd_busy reflects the scoreboard state only.
  - The stage that consumes the read is responsible for forwarding.

Test Plan:
- Reset and x0:
  - Stimulus: hold rst_n=0 for 3 cycles, then release; write 0xDEAD to x0; read ports on x0 and x5.
  - Required response: rd_data=0 on all ports, busy_vec=0, and x0 still reads 0.
- Multi-write priority (NWR=2):
  - Stimulus: port0 writes 0x1111 to x7 and port1 writes 0x2222 to x7 in the same cycle.
  - Required response: next cycle x7 reads 0x2222.
- Scoreboard life cycle:
  - Stimulus: issue x3; on the next cycle, write x3=0x55 without iss_en.
  - Required response: rd_busy=1 on a read of x3 during the cycle after issue, and 0 after the writeback edge, with rd_data=0x55.
- Set/clear collision:
  - Stimulus: in the same cycle, issue x9 and write back x9=0xAA.
  - Required response: busy_vec[9]=1 and x9=0xAA afterwards.
- Bypass (REGFILE_BYPASS_EN defined):
  - Stimulus: x4 is busy; write 0x1234 to x4 while reading x4 in the same cycle.
  - Required response: rd_data=0x1234 and rd_busy=0 in that cycle.
  - Without the macro: old value is returned and rd_busy=1.
- Async reset mid-operation:
  - Stimulus: assert rst_n between edges while x2 is busy and holds 0x77.
  - Required response: x2 reads 0 and busy_vec=0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port integer register file with a per-register busy scoreboard for issue/stall logic.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
   parameter int XLEN  = 64,
   parameter int NREGS = 32,
   parameter int NRD   = 2,
   parameter int NWR   = 1,
   localparam int AW   = $clog2(NREGS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NRD*AW-1:0]     rd_addr,
   output logic [NRD*XLEN-1:0]   rd_data,
   output logic [NRD-1:0]        rd_busy,
   input  logic [NWR-1:0]        wr_en,
   input  logic [NWR*AW-1:0]     wr_addr,
   input  logic [NWR*XLEN-1:0]   wr_data,
   input  logic                  iss_en,
   input  logic [AW-1:0]         iss_rd,
   output logic [NREGS-1:0]      busy_vec
);

   logic [XLEN-1:0]  regs [NREGS];
   logic [NREGS-1:0] busy;
   logic [NREGS-1:0] busy_nxt;

   // Ports are visited in ascending order so the highest-index writer lands last and wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NREGS; k++) begin
            regs[k] <= '0;
         end
      end else begin
         for (int j = 0; j < NWR; j++) begin
            if (wr_en[j] && (wr_addr[j*AW +: AW] != '0)) begin
               regs[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
            end
         end
      end
   end

   // Clears are applied before the issue set so a newer producer keeps the register busy.
   always_comb begin
      busy_nxt = busy;
      for (int j = 0; j < NWR; j++) begin
         if (wr_en[j] && (wr_addr[j*AW +: AW] != '0)) begin
            busy_nxt[wr_addr[j*AW +: AW]] = 1'b0;
         end
      end
      if (iss_en && (iss_rd != '0)) begin
         busy_nxt[iss_rd] = 1'b1;
      end
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= '0;
      end else begin
         busy <= busy_nxt;
      end
   end

   assign busy_vec = busy;

   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [AW-1:0]   addr;
      logic [XLEN-1:0] data;
      logic            pend;
`ifdef REGFILE_BYPASS_EN
      logic            fwd;
`endif

      assign addr = rd_addr[i*AW +: AW];

      always_comb begin
         data = regs[addr];
         pend = busy[addr];
`ifdef REGFILE_BYPASS_EN
         fwd = 1'b0;
         for (int j = 0; j < NWR; j++) begin
            if (wr_en[j] && (wr_addr[j*AW +: AW] == addr)) begin
               data = wr_data[j*XLEN +: XLEN];
               fwd  = 1'b1;
            end
         end
         // A same-cycle reissue of this register means the forwarded value is already stale.
         if (fwd && !(iss_en && (iss_rd == addr))) begin
            pend = 1'b0;
         end
`endif
         if (addr == '0) begin
            data = '0;
            pend = 1'b0;
         end
      end

      assign rd_data[i*XLEN +: XLEN] = data;
      assign rd_busy[i]              = pend;
   end

endmodule
